// File: rtl/sigmoid_taylor_core.sv
// rtl/sigmoid_taylor_core.sv - Q4.8 -> Q1.12 logistic sigmoid, piecewise cubic Taylor, 1-cycle latency
module sigmoid_taylor_core (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] x,
   output logic [12:0] f_x
);

   logic [10:0]        w_a;
   logic [2:0]         w_seg;
   logic signed [8:0]  w_d;
   logic signed [17:0] w_k0, w_k1, w_k2, w_k3;
   logic signed [26:0] w_t3;
   logic signed [27:0] w_h2;
   logic signed [36:0] w_t2;
   logic signed [37:0] w_h1;
   logic signed [46:0] w_t1;
   logic signed [47:0] w_p;
   logic signed [47:0] w_pr;
   logic signed [19:0] w_q;
   logic [12:0]        w_p_sat;
   logic [12:0]        w_f_next;
   logic [12:0]        r_f_x;

   assign w_a   = x[11] ? (~x[10:0] + 11'd1) : x[10:0];
   assign w_seg = w_a[10:8];
   assign w_d   = $signed({1'b0, w_a[7:0]}) - 9'sd128;

   // Q1.16 Taylor coefficients about c = seg + 0.5: s(c), s'(c), s''(c)/2, s'''(c)/6
   always_comb begin
      w_k0 = 18'sd0;
      w_k1 = 18'sd0;
      w_k2 = 18'sd0;
      w_k3 = 18'sd0;
      case (w_seg)
         3'd0: begin w_k0 = 18'sd40793; w_k1 = 18'sd15401; w_k2 = -18'sd1886; w_k3 = -18'sd1052; end
         3'd1: begin w_k0 = 18'sd53581; w_k1 = 18'sd9774;  w_k2 = -18'sd3104; w_k3 = 18'sd171;   end
         3'd2: begin w_k0 = 18'sd60565; w_k1 = 18'sd4594;  w_k2 = -18'sd1949; w_k3 = 18'sd444;   end
         3'd3: begin w_k0 = 18'sd63615; w_k1 = 18'sd1865;  w_k2 = -18'sd878;  w_k3 = 18'sd258;   end
         3'd4: begin w_k0 = 18'sd64816; w_k1 = 18'sd712;   w_k2 = -18'sd348;  w_k3 = 18'sd111;   end
         3'd5: begin w_k0 = 18'sd65269; w_k1 = 18'sd266;   w_k2 = -18'sd132;  w_k3 = 18'sd43;    end
         3'd6: begin w_k0 = 18'sd65438; w_k1 = 18'sd98;    w_k2 = -18'sd49;   w_k3 = 18'sd16;    end
         default: begin w_k0 = 18'sd65500; w_k1 = 18'sd36; w_k2 = -18'sd18;   w_k3 = 18'sd6;     end
      endcase
   end

   // Horner chain; each stage widened so no bit is ever dropped (frac 24 -> 32 -> 40)
   assign w_t3 = 27'(w_k3) * 27'(w_d);
   assign w_h2 = 28'(w_t3) + (28'(w_k2) <<< 8);
   assign w_t2 = 37'(w_h2) * 37'(w_d);
   assign w_h1 = 38'(w_t2) + (38'(w_k1) <<< 16);
   assign w_t1 = 47'(w_h1) * 47'(w_d);
   assign w_p  = 48'(w_t1) + (48'(w_k0) <<< 24);
   assign w_pr = w_p + (48'sd1 <<< 27);
   assign w_q  = 20'(w_pr >>> 28);

   always_comb begin
      w_p_sat = w_q[12:0];
      if (w_q < 20'sd0)
         w_p_sat = 13'h0000;
      else if (w_q > 20'sd4096)
         w_p_sat = 13'h1000;
   end

   // Both signs share one magnitude result, so f(x) + f(-x) is exactly 1.0
   always_comb begin
      w_f_next = w_p_sat;
      if (x == 12'h000)
         w_f_next = 13'h0800;
      else if (x == 12'h800)
         w_f_next = 13'h0000;
      else if (x[11])
         w_f_next = 13'h1000 - w_p_sat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_f_x <= 13'h0000;
      else
         r_f_x <= w_f_next;
   end

   assign f_x = r_f_x;

endmodule

// File: tb/tb_sigmoid_taylor_core.sv
// tb/tb_sigmoid_taylor_core.sv - directed and exhaustive self-checking bench for sigmoid_taylor_core
module tb_sigmoid_taylor_core;

   logic        clk;
   logic        reset_n;
   logic [11:0] x;
   logic [12:0] f_x;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [12:0] res [0:4095];

   sigmoid_taylor_core dut (
      .clk     (clk),
      .reset_n (reset_n),
      .x       (x),
      .f_x     (f_x)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic real sig_ref(input logic [11:0] code);
      real xv;
      xv = $itor($signed(code)) / 256.0;
      return 1.0 / (1.0 + $exp(-xv));
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      x = 12'h100;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (f_x !== 13'h0000) begin
         n_bad++;
         $display("FAIL reset_hold: got %h want 0000", f_x);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h0BAE || f_x > 13'h0BB6) begin
         n_bad++;
         $display("FAIL reset_release: got %h want 0BB2+/-4", f_x);
      end
   endtask

   task automatic test_centre();
      x = 12'h000;
      @(negedge clk);
      n_cmp++;
      if (f_x !== 13'h0800) begin
         n_bad++;
         $display("FAIL centre_zero: got %h want 0800", f_x);
      end
      x = 12'h800;
      @(negedge clk);
      n_cmp++;
      if (f_x !== 13'h0000) begin
         n_bad++;
         $display("FAIL min_code: got %h want 0000", f_x);
      end
      x = 12'h7FF;
      @(negedge clk);
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h0FFD || f_x > 13'h1000) begin
         n_bad++;
         $display("FAIL max_code: got %h want 0FFD..1000", f_x);
      end
   endtask

   task automatic test_spot();
      logic [12:0] v_pos;
      logic [12:0] v_neg;
      x = 12'h280;
      @(negedge clk);
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h0EC5 || f_x > 13'h0ECD) begin
         n_bad++;
         $display("FAIL spot_2p5: got %h want 0EC9+/-4", f_x);
      end
      x = 12'h300;
      @(negedge clk);
      v_pos = f_x;
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h0F3A || f_x > 13'h0F42) begin
         n_bad++;
         $display("FAIL spot_p3: got %h want 0F3E+/-4", f_x);
      end
      x = 12'hD00;
      @(negedge clk);
      v_neg = f_x;
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h00BE || f_x > 13'h00C6) begin
         n_bad++;
         $display("FAIL spot_m3: got %h want 00C2+/-4", f_x);
      end
      n_cmp++;
      if (14'(v_pos) + 14'(v_neg) !== 14'h1000) begin
         n_bad++;
         $display("FAIL spot_sym: got %h+%h want sum 1000", v_pos, v_neg);
      end
   endtask

   task automatic test_back_to_back();
      x = 12'h100;
      @(negedge clk);
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h0BAE || f_x > 13'h0BB6) begin
         n_bad++;
         $display("FAIL b2b_0: got %h want 0BB2+/-4", f_x);
      end
      x = 12'hF00;
      @(negedge clk);
      n_cmp++;
      if ($isunknown(f_x) || f_x < 13'h044A || f_x > 13'h0452) begin
         n_bad++;
         $display("FAIL b2b_1: got %h want 044E+/-4", f_x);
      end
      x = 12'h000;
      @(negedge clk);
      n_cmp++;
      if (f_x !== 13'h0800) begin
         n_bad++;
         $display("FAIL b2b_2: got %h want 0800", f_x);
      end
   endtask

   task automatic test_reset_mid();
      x = 12'h300;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (f_x !== 13'h0000) begin
         n_bad++;
         $display("FAIL async_clear: got %h want 0000", f_x);
      end
      @(negedge clk);
      n_cmp++;
      if (f_x !== 13'h0000) begin
         n_bad++;
         $display("FAIL reset_held_edge: got %h want 0000", f_x);
      end
      reset_n = 1'b1;
      x = 12'h000;
      @(negedge clk);
      n_cmp++;
      if (f_x !== 13'h0800) begin
         n_bad++;
         $display("FAIL first_after_release: got %h want 0800", f_x);
      end
   endtask

   task automatic test_sweep();
      real err;
      real sum_e  = 0.0;
      real sum_e2 = 0.0;
      real max_e  = 0.0;
      real mean_e;
      logic [12:0] prev;
      logic [11:0] code;
      for (int i = 0; i < 4096; i++) begin
         x = 12'(i);
         @(negedge clk);
         res[i] = f_x;
      end
      for (int i = 0; i < 4096; i++) begin
         err = $itor(res[i]) / 4096.0 - sig_ref(12'(i));
         sum_e  += err;
         sum_e2 += err * err;
         if ((err < 0.0 ? -err : err) > max_e) max_e = (err < 0.0 ? -err : err);
         n_cmp++;
         if ($isunknown(res[i]) || err > 1.0 / 1024.0 || err < -1.0 / 1024.0) begin
            n_bad++;
            $display("FAIL sweep_acc x=%h: got %h (err %f) want |err|<=0.000977", 12'(i), res[i], err);
         end
      end
      for (int i = 1; i < 4096; i++) begin
         if (i != 12'h800) begin
            code = 12'(4096 - i);
            n_cmp++;
            if (14'(res[i]) + 14'(res[code]) !== 14'h1000) begin
               n_bad++;
               $display("FAIL sweep_sym x=%h: got %h+%h want sum 1000", 12'(i), res[i], res[code]);
            end
         end
      end
      prev = res[12'h800];
      for (int s = -2047; s < 2048; s++) begin
         code = 12'(s);
         n_cmp++;
         if (res[code] < prev) begin
            n_bad++;
            $display("FAIL sweep_mono x=%h: got %h want >= %h", code, res[code], prev);
         end
         prev = res[code];
      end
      mean_e = sum_e / 4096.0;
      $display("sweep: max_abs_err=%f mean_err=%f std_err=%f", max_e, mean_e,
               $sqrt(sum_e2 / 4096.0 - mean_e * mean_e));
   endtask

   initial begin
      reset_n = 1'b0;
      x = 12'h000;
      test_reset();
      test_centre();
      test_spot();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
